// File: rtl/game_state_ctrl_if.sv
// Bus between the Pacman top level and the game-rules engine: positions and
// event strobes in, game status out.
interface game_state_ctrl_if #(
  parameter int unsigned NUM_GHOSTS  = 3,
  parameter int unsigned NUM_PELLETS = 3,
  parameter int unsigned COORD_W     = 10,
  parameter int unsigned SCORE_W     = 11
);
  logic                           frame_tick;
  logic [COORD_W-1:0]             pacman_x;
  logic [COORD_W-1:0]             pacman_y;
  logic [NUM_GHOSTS*COORD_W-1:0]  ghost_x;
  logic [NUM_GHOSTS*COORD_W-1:0]  ghost_y;
  logic [NUM_PELLETS*COORD_W-1:0] pellet_x;
  logic [NUM_PELLETS*COORD_W-1:0] pellet_y;
  logic                           dot_eaten;
  logic                           dots_clear;
  logic [2:0]                     state;
  logic [1:0]                     lives;
  logic [SCORE_W-1:0]             score;
  logic                           reversal;
  logic                           is_defeated;
  logic                           death;
  logic                           victory;
  logic [NUM_GHOSTS-1:0]          ghost_enable;
  logic [NUM_PELLETS-1:0]         pellet_on;

  modport master (
    output frame_tick, pacman_x, pacman_y, ghost_x, ghost_y, pellet_x, pellet_y,
           dot_eaten, dots_clear,
    input  state, lives, score, reversal, is_defeated, death, victory,
           ghost_enable, pellet_on
  );

  modport slave (
    input  frame_tick, pacman_x, pacman_y, ghost_x, ghost_y, pellet_x, pellet_y,
           dot_eaten, dots_clear,
    output state, lives, score, reversal, is_defeated, death, victory,
           ghost_enable, pellet_on
  );
endinterface

// File: rtl/game_state_ctrl.sv
// Pacman game-rules engine: serial ghost/pellet collision scan with one shared
// squared-distance datapath, lives, power mode, respawn, score and win/lose.
module game_state_ctrl #(
  parameter int unsigned NUM_GHOSTS     = 3,
  parameter int unsigned NUM_PELLETS    = 3,
  parameter int unsigned COORD_W        = 10,
  parameter int unsigned LIVES_INIT     = 2,
  parameter int unsigned HIT_RADIUS_SQ  = 64,
  parameter int unsigned POWER_FRAMES   = 600,
  parameter int unsigned RESPAWN_FRAMES = 300,
  parameter int unsigned DEATH_FRAMES   = 120,
  parameter int unsigned SCORE_W        = 11,
  parameter int unsigned WIN_SCORE      = 150,
  parameter int unsigned GHOST_PTS      = 10,
  parameter int unsigned PELLET_PTS     = 5
) (
  input  logic               Clk,
  input  logic               Reset_n,
  game_state_ctrl_if.slave   bus
);

  localparam int unsigned NE     = NUM_GHOSTS + NUM_PELLETS;
  localparam int unsigned IDX_W  = $clog2(NE + 1);
  localparam int unsigned DIST_W = 2 * COORD_W + 3;
  localparam int unsigned PWR_W  = $clog2(POWER_FRAMES + 1);
  localparam int unsigned RSP_W  = $clog2(RESPAWN_FRAMES + 1);
  localparam int unsigned DTH_W  = $clog2(DEATH_FRAMES + 1);
  localparam int unsigned SUM_W  = SCORE_W + 2;
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  typedef enum logic [2:0] {
    ST_PLAY     = 3'd0,
    ST_POWER    = 3'd1,
    ST_DYING    = 3'd2,
    ST_GAMEOVER = 3'd3,
    ST_WIN      = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic [1:0]           lives_q, lives_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [PWR_W-1:0]     power_q, power_d;
  logic [DTH_W-1:0]     death_q, death_d;
  logic [RSP_W-1:0]     respawn_q [NUM_GHOSTS];
  logic [RSP_W-1:0]     respawn_d [NUM_GHOSTS];
  logic [1:0]           chain_q, chain_d;
  logic [NUM_GHOSTS-1:0]  ghost_en_q, ghost_en_d;
  logic [NUM_PELLETS-1:0] pellet_on_q, pellet_on_d;
  logic                 busy_q, busy_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 jvld_q, jvld_d;
  logic [IDX_W-1:0]     jidx_q, jidx_d;
  logic [DIST_W-1:0]    dist_q, dist_d;
  logic                 reversal_q, defeated_q, death_flag_q, victory_q;

  logic [COORD_W-1:0]   ent_x, ent_y;
  logic signed [COORD_W:0] dx, dy;
  logic [COORD_W:0]     adx, ady;
  logic                 close;
  logic [NUM_GHOSTS-1:0]  ghost_hit_vec;
  logic [NUM_PELLETS-1:0] pellet_hit_vec;
  logic                 alive, term;
  logic [SUM_W-1:0]     award, score_sum;

  // Distance stage: mux one entity, square magnitudes so no signed wrap can occur.
  always_comb begin
    ent_x = '0;
    ent_y = '0;
    for (int unsigned i = 0; i < NUM_GHOSTS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        ent_x = bus.ghost_x[i*COORD_W +: COORD_W];
        ent_y = bus.ghost_y[i*COORD_W +: COORD_W];
      end
    end
    for (int unsigned j = 0; j < NUM_PELLETS; j++) begin
      if (idx_q == IDX_W'(j + NUM_GHOSTS)) begin
        ent_x = bus.pellet_x[j*COORD_W +: COORD_W];
        ent_y = bus.pellet_y[j*COORD_W +: COORD_W];
      end
    end
    dx = $signed({1'b0, ent_x}) - $signed({1'b0, bus.pacman_x});
    dy = $signed({1'b0, ent_y}) - $signed({1'b0, bus.pacman_y});
    adx = dx[COORD_W] ? $unsigned(-dx) : $unsigned(dx);
    ady = dy[COORD_W] ? $unsigned(-dy) : $unsigned(dy);
    dist_d = DIST_W'(adx) * DIST_W'(adx) + DIST_W'(ady) * DIST_W'(ady);
  end

  always_comb begin
    close = jvld_q && (dist_q < DIST_W'(HIT_RADIUS_SQ));
    for (int unsigned i = 0; i < NUM_GHOSTS; i++)
      ghost_hit_vec[i] = close && (jidx_q == IDX_W'(i)) && ghost_en_q[i];
    for (int unsigned j = 0; j < NUM_PELLETS; j++)
      pellet_hit_vec[j] = close && (jidx_q == IDX_W'(j + NUM_GHOSTS)) && pellet_on_q[j];
  end

  always_comb begin
    state_d     = state_q;
    lives_d     = lives_q;
    power_d     = power_q;
    death_d     = death_q;
    respawn_d   = respawn_q;
    chain_d     = chain_q;
    ghost_en_d  = ghost_en_q;
    pellet_on_d = pellet_on_q;
    busy_d      = busy_q;
    idx_d       = idx_q;
    jvld_d      = 1'b0;
    jidx_d      = idx_q;
    award       = '0;
    alive = (state_q == ST_PLAY) || (state_q == ST_POWER);
    term  = (state_q == ST_GAMEOVER) || (state_q == ST_WIN);

    if (busy_q) begin
      jvld_d = (idx_q != IDX_W'(NE));
      if (idx_q == IDX_W'(NE)) busy_d = 1'b0;
      else                     idx_d  = idx_q + 1'b1;
    end else if (bus.frame_tick && alive) begin
      busy_d = 1'b1;
      idx_d  = '0;
    end

    if (bus.frame_tick && !term) begin
      if (power_q != '0) begin
        power_d = power_q - 1'b1;
        if (power_q == PWR_W'(1) && state_q == ST_POWER) state_d = ST_PLAY;
      end
      for (int unsigned i = 0; i < NUM_GHOSTS; i++) begin
        if (respawn_q[i] != '0) begin
          respawn_d[i] = respawn_q[i] - 1'b1;
          if (respawn_q[i] == RSP_W'(1)) ghost_en_d[i] = 1'b1;
        end
      end
      if (state_q == ST_DYING) begin
        death_d = death_q - 1'b1;
        if (death_q == DTH_W'(1)) begin
          state_d = ST_PLAY;
          power_d = '0;
        end
      end
    end

    // Scan events are applied after the timers so a hit overrides a same-tick expiry.
    if (alive && (|ghost_hit_vec)) begin
      if (state_q == ST_PLAY) begin
        busy_d = 1'b0;
        jvld_d = 1'b0;
        if (lives_q == '0) begin
          state_d = ST_GAMEOVER;
        end else begin
          lives_d = lives_q - 1'b1;
          death_d = DTH_W'(DEATH_FRAMES);
          state_d = ST_DYING;
        end
      end else begin
        for (int unsigned i = 0; i < NUM_GHOSTS; i++) begin
          if (ghost_hit_vec[i]) begin
            ghost_en_d[i] = 1'b0;
            respawn_d[i]  = RSP_W'(RESPAWN_FRAMES);
          end
        end
        award   = SUM_W'(GHOST_PTS) << chain_q;
        chain_d = (chain_q == 2'd3) ? 2'd3 : chain_q + 2'd1;
      end
    end

    if (alive && (|pellet_hit_vec)) begin
      pellet_on_d = pellet_on_q & ~pellet_hit_vec;
      award       = SUM_W'(PELLET_PTS);
      power_d     = PWR_W'(POWER_FRAMES);
      chain_d     = 2'd0;
      state_d     = ST_POWER;
    end

    score_sum = {2'b00, score_q} + award + SUM_W'(bus.dot_eaten && !term);
    if (term)                              score_d = score_q;
    else if (score_sum > {2'b00, SCORE_MAX}) score_d = SCORE_MAX;
    else                                   score_d = score_sum[SCORE_W-1:0];

    // Win is judged on the post-update score and beats a same-cycle ghost hit.
    if (alive && ((score_d >= SCORE_W'(WIN_SCORE)) || bus.dots_clear)) begin
      state_d = ST_WIN;
      lives_d = lives_q;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q      <= ST_PLAY;
      lives_q      <= 2'(LIVES_INIT);
      score_q      <= '0;
      power_q      <= '0;
      death_q      <= '0;
      for (int unsigned i = 0; i < NUM_GHOSTS; i++) respawn_q[i] <= '0;
      chain_q      <= '0;
      ghost_en_q   <= '1;
      pellet_on_q  <= '1;
      busy_q       <= 1'b0;
      idx_q        <= '0;
      jvld_q       <= 1'b0;
      jidx_q       <= '0;
      dist_q       <= '0;
      reversal_q   <= 1'b0;
      defeated_q   <= 1'b0;
      death_flag_q <= 1'b0;
      victory_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      lives_q      <= lives_d;
      score_q      <= score_d;
      power_q      <= power_d;
      death_q      <= death_d;
      respawn_q    <= respawn_d;
      chain_q      <= chain_d;
      ghost_en_q   <= ghost_en_d;
      pellet_on_q  <= pellet_on_d;
      busy_q       <= busy_d;
      idx_q        <= idx_d;
      jvld_q       <= jvld_d;
      jidx_q       <= jidx_d;
      dist_q       <= dist_d;
      reversal_q   <= (state_d == ST_POWER);
      defeated_q   <= (state_d == ST_DYING);
      death_flag_q <= (state_d == ST_GAMEOVER);
      victory_q    <= (state_d == ST_WIN);
    end
  end

  assign bus.state        = state_q;
  assign bus.lives        = lives_q;
  assign bus.score        = score_q;
  assign bus.reversal     = reversal_q;
  assign bus.is_defeated  = defeated_q;
  assign bus.death        = death_flag_q;
  assign bus.victory      = victory_q;
  assign bus.ghost_enable = ghost_en_q;
  assign bus.pellet_on    = pellet_on_q;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Bench for game_state_ctrl: distance vector table, directed rule sequences and
// randomized frames checked every cycle against a frame-level rules model.
module tb_game_state_ctrl;
  localparam int NG = 3;
  localparam int NP = 3;
  localparam int NE = NG + NP;
  localparam int CW = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  game_state_ctrl_if #(.NUM_GHOSTS(NG), .NUM_PELLETS(NP), .COORD_W(CW), .SCORE_W(11)) bus ();

  game_state_ctrl #(.NUM_GHOSTS(NG), .NUM_PELLETS(NP), .COORD_W(CW), .SCORE_W(11)) dut (
    .Clk(clk), .Reset_n(rst_n), .bus(bus)
  );

  int nchk = 0;
  int nerr = 0;
  int pac_x, pac_y;
  int gx[NG], gy[NG], px[NP], py[NP];
  int tk, dt, dc;

  // rules model state
  int m_state, m_lives, m_score, m_pcnt, m_dcnt, m_chain, m_start, mcyc;
  int m_rcnt[NG];
  bit m_gen[NG];
  bit m_pon[NP];

  typedef struct { int px; int py; int gx; int gy; bit hit; } dvec_t;
  dvec_t vt[10];

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply_pos();
    bus.pacman_x = pac_x[CW-1:0];
    bus.pacman_y = pac_y[CW-1:0];
    for (int i = 0; i < NG; i++) begin
      bus.ghost_x[i*CW +: CW] = gx[i][CW-1:0];
      bus.ghost_y[i*CW +: CW] = gy[i][CW-1:0];
    end
    for (int j = 0; j < NP; j++) begin
      bus.pellet_x[j*CW +: CW] = px[j][CW-1:0];
      bus.pellet_y[j*CW +: CW] = py[j][CW-1:0];
    end
  endtask

  task automatic far();
    pac_x = 500; pac_y = 500;
    for (int i = 0; i < NG; i++) begin gx[i] = 100 + 50 * i; gy[i] = 100; end
    for (int j = 0; j < NP; j++) begin px[j] = 800 + 50 * j; py[j] = 900; end
    apply_pos();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.frame_tick = 1'b0; bus.dot_eaten = 1'b0; bus.dots_clear = 1'b0;
    far();
    step(2);
    rst_n = 1'b1;
  endtask

  task automatic do_tick();
    bus.frame_tick = 1'b1;
    step(1);
    bus.frame_tick = 1'b0;
    step(NE + 2);
  endtask

  task automatic ticks(input int n);
    repeat (n) do_tick();
  endtask

  function automatic int d2(input int ax, input int ay, input int bx, input int by);
    return (ax - bx) * (ax - bx) + (ay - by) * (ay - by);
  endfunction

  task automatic model_reset();
    m_state = 0; m_lives = 2; m_score = 0; m_pcnt = 0; m_dcnt = 0; m_chain = 0;
    m_start = -1; mcyc = 0;
    for (int i = 0; i < NG; i++) begin m_rcnt[i] = 0; m_gen[i] = 1'b1; end
    for (int j = 0; j < NP; j++) m_pon[j] = 1'b1;
  endtask

  // One clock edge of the rules: entity k of a frame is judged 2+k edges after its tick.
  task automatic model_step();
    bit alive, term, busy;
    int k, gh, ph, nst, award, sc;
    alive = (m_state == 0) || (m_state == 1);
    term  = (m_state >= 3);
    busy  = (m_start >= 0) && (mcyc >= m_start + 1) && (mcyc <= m_start + NE + 1);
    k  = (m_start >= 0) ? mcyc - m_start - 2 : -1;
    gh = -1; ph = -1;
    if (alive && k >= 0 && k < NE) begin
      if (k < NG) begin
        if (m_gen[k] && d2(gx[k], gy[k], pac_x, pac_y) < 64) gh = k;
      end else begin
        if (m_pon[k-NG] && d2(px[k-NG], py[k-NG], pac_x, pac_y) < 64) ph = k - NG;
      end
    end
    nst = m_state; award = 0;
    if (tk != 0 && !term) begin
      if (m_pcnt > 0) begin
        m_pcnt--;
        if (m_pcnt == 0 && m_state == 1) nst = 0;
      end
      for (int i = 0; i < NG; i++)
        if (m_rcnt[i] > 0) begin
          m_rcnt[i]--;
          if (m_rcnt[i] == 0) m_gen[i] = 1'b1;
        end
      if (m_state == 2) begin
        m_dcnt--;
        if (m_dcnt == 0) begin nst = 0; m_pcnt = 0; end
      end
    end
    if (gh >= 0) begin
      if (m_state == 0) begin
        m_start = -1;
        if (m_lives == 0) nst = 3;
        else begin m_lives--; m_dcnt = 120; nst = 2; end
      end else begin
        m_gen[gh] = 1'b0; m_rcnt[gh] = 300;
        award = 10 * (1 << m_chain);
        m_chain = (m_chain == 3) ? 3 : m_chain + 1;
      end
    end
    if (ph >= 0) begin
      m_pon[ph] = 1'b0; award = 5; m_pcnt = 600; m_chain = 0; nst = 1;
    end
    if (tk != 0 && alive && !busy) m_start = mcyc;
    if (!term) begin
      sc = m_score + award + dt;
      m_score = (sc > 2047) ? 2047 : sc;
    end
    if (alive && (m_score >= 150 || dc != 0)) nst = 4;
    m_state = nst;
    mcyc++;
  endtask

  task automatic rand_cmp();
    int ge, pe;
    ge = 0; pe = 0;
    for (int i = 0; i < NG; i++) ge |= int'(m_gen[i]) << i;
    for (int j = 0; j < NP; j++) pe |= int'(m_pon[j]) << j;
    chk("rnd_state", int'(bus.state), m_state);
    chk("rnd_lives", int'(bus.lives), m_lives);
    chk("rnd_score", int'(bus.score), m_score);
    chk("rnd_ghost_enable", int'(bus.ghost_enable), ge);
    chk("rnd_pellet_on", int'(bus.pellet_on), pe);
    chk("rnd_flags", int'({bus.reversal, bus.is_defeated, bus.death, bus.victory}),
        (int'(m_state == 1) << 3) | (int'(m_state == 2) << 2) | (int'(m_state == 3) << 1) | int'(m_state == 4));
  endtask

  function automatic int near(input int c);
    int v;
    v = c + int'($urandom_range(0, 18)) - 9;
    if (v < 0) v = 0;
    if (v > 1023) v = 1023;
    return v;
  endfunction

  initial begin
    vt[0] = '{500, 500, 503, 503, 1'b1};
    vt[1] = '{500, 500, 493, 500, 1'b1};
    vt[2] = '{500, 500, 492, 500, 1'b0};
    vt[3] = '{5,   5,   0,   0,   1'b1};
    vt[4] = '{0,   0,   1023, 1023, 1'b0};
    vt[5] = '{1023, 0,  0,   0,   1'b0};
    vt[6] = '{500, 500, 506, 506, 1'b0};
    vt[7] = '{500, 500, 504, 507, 1'b0};
    vt[8] = '{500, 500, 507, 503, 1'b1};
    vt[9] = '{7,   500, 0,   500, 1'b1};

    do_reset();
    step(1);
    chk("reset_state", int'(bus.state), 0);
    chk("reset_lives", int'(bus.lives), 2);
    chk("reset_score", int'(bus.score), 0);
    chk("reset_ghost_enable", int'(bus.ghost_enable), 7);
    chk("reset_pellet_on", int'(bus.pellet_on), 7);
    chk("reset_flags", int'({bus.reversal, bus.is_defeated, bus.death, bus.victory}), 0);

    foreach (vt[n]) begin
      do_reset();
      pac_x = vt[n].px; pac_y = vt[n].py; gx[0] = vt[n].gx; gy[0] = vt[n].gy;
      apply_pos();
      do_tick();
      chk($sformatf("dist%0d_state", n), int'(bus.state), vt[n].hit ? 2 : 0);
      chk($sformatf("dist%0d_lives", n), int'(bus.lives), vt[n].hit ? 1 : 2);
    end

    // DYING lasts exactly 120 frames
    do_reset();
    gx[0] = 503; gy[0] = 503; apply_pos();
    do_tick();
    chk("dying_enter", int'(bus.state), 2);
    chk("dying_lives", int'(bus.lives), 1);
    chk("dying_flag", int'(bus.is_defeated), 1);
    far();
    ticks(119);
    chk("dying_119", int'(bus.state), 2);
    do_tick();
    chk("dying_120", int'(bus.state), 0);
    chk("dying_flag_clr", int'(bus.is_defeated), 0);

    // power pellet: 600 frames of POWER
    do_reset();
    px[1] = 500; py[1] = 500; apply_pos();
    do_tick();
    chk("pellet_on", int'(bus.pellet_on), 5);
    chk("pellet_score", int'(bus.score), 5);
    chk("pellet_state", int'(bus.state), 1);
    chk("pellet_reversal", int'(bus.reversal), 1);
    ticks(599);
    chk("power_599", int'(bus.state), 1);
    do_tick();
    chk("power_600", int'(bus.state), 0);
    chk("power_rev_clr", int'(bus.reversal), 0);

    // ghost chain and respawn timing
    do_reset();
    px[0] = 500; py[0] = 500; apply_pos();
    do_tick();
    chk("chain_pellet", int'(bus.score), 5);
    px[0] = 800; gx[0] = 500; gy[0] = 500; apply_pos();
    do_tick();
    chk("chain_g0_score", int'(bus.score), 15);
    chk("chain_g0_en", int'(bus.ghost_enable), 6);
    gx[0] = 100; gy[0] = 100; gx[1] = 502; gy[1] = 498; apply_pos();
    do_tick();
    chk("chain_g1_score", int'(bus.score), 35);
    gx[1] = 150; gy[1] = 100; gx[2] = 500; gy[2] = 501; apply_pos();
    do_tick();
    chk("chain_g2_score", int'(bus.score), 75);
    chk("chain_all_off", int'(bus.ghost_enable), 0);
    gx[2] = 200; gy[2] = 100; apply_pos();
    ticks(297);
    chk("respawn_299", int'(bus.ghost_enable), 0);
    do_tick();
    chk("respawn_300", int'(bus.ghost_enable), 1);
    chk("respawn_power", int'(bus.state), 1);

    // last life lost -> GAMEOVER, then frozen
    do_reset();
    for (int life = 0; life < 2; life++) begin
      gx[0] = 500; gy[0] = 500; apply_pos();
      do_tick();
      far();
      ticks(120);
    end
    chk("go_lives0", int'(bus.lives), 0);
    chk("go_play", int'(bus.state), 0);
    gx[0] = 500; gy[0] = 500; apply_pos();
    do_tick();
    chk("go_state", int'(bus.state), 3);
    chk("go_death", int'(bus.death), 1);
    bus.dot_eaten = 1'b1; step(3); bus.dot_eaten = 1'b0;
    do_tick();
    chk("go_score_frozen", int'(bus.score), 0);
    chk("go_terminal", int'(bus.state), 3);

    // dots_clear wins at once
    do_reset();
    bus.dots_clear = 1'b1; step(1); bus.dots_clear = 1'b0; step(1);
    chk("dots_clear_win", int'(bus.state), 4);

    // score 149 + dot in the same cycle as a ghost hit -> WIN, lives kept
    do_reset();
    bus.dot_eaten = 1'b1; step(149); bus.dot_eaten = 1'b0;
    chk("win_pre_score", int'(bus.score), 149);
    gx[0] = 500; gy[0] = 500; apply_pos();
    bus.frame_tick = 1'b1; step(1); bus.frame_tick = 1'b0;
    step(1);
    bus.dot_eaten = 1'b1; step(1); bus.dot_eaten = 1'b0;
    chk("win_state", int'(bus.state), 4);
    chk("win_score", int'(bus.score), 150);
    chk("win_lives", int'(bus.lives), 2);
    chk("win_victory", int'(bus.victory), 1);
    step(NE + 2);
    chk("win_hold", int'(bus.state), 4);

    // randomized frames against the rules model
    for (int ep = 0; ep < 6; ep++) begin
      int term_frames, e0;
      bit broke;
      do_reset();
      model_reset();
      term_frames = 0; broke = 1'b0;
      for (int f = 0; f < 400 && !broke && term_frames < 5; f++) begin
        int gap;
        if ($urandom_range(0, 3) == 0) begin
          pac_x = ($urandom_range(0, 1) == 0) ? 0 : 1023;
          pac_y = ($urandom_range(0, 1) == 0) ? 0 : 1023;
        end else begin
          pac_x = int'($urandom_range(0, 1023));
          pac_y = int'($urandom_range(0, 1023));
        end
        for (int i = 0; i < NG; i++)
          if ($urandom_range(0, 3) == 0) begin gx[i] = near(pac_x); gy[i] = near(pac_y); end
          else begin gx[i] = int'($urandom_range(0, 1023)); gy[i] = int'($urandom_range(0, 1023)); end
        for (int j = 0; j < NP; j++)
          if ($urandom_range(0, 9) == 0) begin px[j] = near(pac_x); py[j] = near(pac_y); end
          else begin px[j] = int'($urandom_range(0, 1023)); py[j] = int'($urandom_range(0, 1023)); end
        apply_pos();
        gap = NE + 3 + int'($urandom_range(0, 3));
        for (int c = 0; c < gap && !broke; c++) begin
          tk = (c == 0 || (c <= 3 && $urandom_range(0, 7) == 0)) ? 1 : 0;
          dt = ($urandom_range(0, 31) == 0) ? 1 : 0;
          dc = ($urandom_range(0, 3999) == 0) ? 1 : 0;
          bus.frame_tick = tk[0]; bus.dot_eaten = dt[0]; bus.dots_clear = dc[0];
          @(posedge clk);
          model_step();
          #1;
          e0 = nerr;
          rand_cmp();
          if (nerr != e0) broke = 1'b1;
        end
        if (m_state >= 3) term_frames++;
      end
      bus.frame_tick = 1'b0; bus.dot_eaten = 1'b0; bus.dots_clear = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
